// File: rtl/period_meter_ctrl_if.sv
// Control-bus bundle for period_meter_ctrl: start request, busy status and the
// result handshake (p_valid / p_ack) with the measured period and overflow flag.
//
// Handshake: the producer raises p_valid together with stable period/ovf and keeps
// all three unchanged until it sees p_ack=1 on a clock edge. p_valid drops on the
// following cycle. start is a one-cycle request that is honoured only while the
// producer is idle. Requests made at any other time are dropped, not queued.
interface period_meter_ctrl_if #(
   parameter int unsigned PW = 10
);
   logic          start;
   logic          p_ack;
   logic          busy;
   logic          p_valid;
   logic [PW-1:0] period;
   logic          ovf;

   // Consumer / control side
   modport master (
      output start,
      output p_ack,
      input  busy,
      input  p_valid,
      input  period,
      input  ovf
   );

   // Measurement sequencer side
   modport slave (
      input  start,
      input  p_ack,
      output busy,
      output p_valid,
      output period,
      output ovf
   );
endinterface

// File: rtl/period_meter_ctrl.sv
// period_meter_ctrl: arms on start, synchronises the async event pin ne_i, counts
// DIV-cycle ticks between two rising edges and presents the saturating result on
// a valid/ack handshake.
// Optional build macro PM_AVG4_EN: average over 4 consecutive periods (capture on
// the 4th rise after arming, PW+2 bit accumulator, result = acc >> 2).
// state_o exposes the FSM state: 0 IDLE, 1 ARM, 2 MEAS, 3 HOLD.
module period_meter_ctrl #(
   parameter int unsigned DIV = 100,
   parameter int unsigned PW  = 10
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      ne_i,
   period_meter_ctrl_if.slave        bus,
   output logic [1:0]                state_o
);

   localparam int unsigned PSW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PSW-1:0] PS_RELOAD = PSW'(DIV - 1);
`ifdef PM_AVG4_EN
   localparam int unsigned CW = PW + 2;
`else
   localparam int unsigned CW = PW;
`endif
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_MEAS = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t         state_q, state_d;

   logic           s1_q, s2_q, s3_q;
   logic           rise;

   logic [PSW-1:0] presc_q;
   logic [CW-1:0]  cnt_q;
   logic           ovf_int_q;

   logic [PW-1:0]  period_q;
   logic           ovf_q;
   logic           p_valid_q;
   logic           busy_q;

   // FSM controls
   logic           arm_clr;
   logic           arm_load;
   logic           meas_run;
   logic           cap_en;
   logic           last_rise;

   // datapath helpers
   logic           tick;
   logic           cnt_sat;
   logic [CW-1:0]  cnt_inc;
   logic [CW-1:0]  cnt_cap;
   logic           ovf_cap;

   // Two-flop synchroniser plus delay flop for rising-edge detection on ne_i
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= ne_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise = s2_q & ~s3_q;

`ifdef PM_AVG4_EN
   logic [1:0] ec_q;

   // Edge counter: counts rises inside MEAS, the 4th one closes the average
   always_ff @(posedge clk_i) begin
      if (rst_i || arm_clr) begin
         ec_q <= 2'd0;
      end else if (meas_run && rise && (ec_q != 2'd3)) begin
         ec_q <= ec_q + 2'd1;
      end
   end

   assign last_rise = rise && (ec_q == 2'd3);
`else
   assign last_rise = rise;
`endif

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.start)  state_d = S_ARM;
         S_ARM:  if (rise)       state_d = S_MEAS;
         S_MEAS: if (last_rise)  state_d = S_HOLD;
         S_HOLD: if (bus.p_ack)  state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
   end

   // FSM output decode: datapath controls per state
   always_comb begin
      arm_clr  = 1'b0;
      arm_load = 1'b0;
      meas_run = 1'b0;
      cap_en   = 1'b0;
      case (state_q)
         S_ARM: begin
            arm_clr  = 1'b1;
            arm_load = rise;
         end
         S_MEAS: begin
            meas_run = 1'b1;
            cap_en   = last_rise;
         end
         default: ;
      endcase
   end

   assign tick    = meas_run && (presc_q == '0);
   assign cnt_sat = (cnt_q == CNT_MAX);
   assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CW'(1);
   // A tick coinciding with the closing rise is part of the captured value
   assign cnt_cap = tick ? cnt_inc : cnt_q;
   assign ovf_cap = ovf_int_q | (tick & cnt_sat);

   // Prescaler: loaded on the arming rise, free-running down-counter while measuring
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         presc_q <= '0;
      end else if (arm_load) begin
         presc_q <= PS_RELOAD;
      end else if (meas_run) begin
         presc_q <= (presc_q == '0) ? PS_RELOAD : presc_q - PSW'(1);
      end
   end

   // Tick counter / accumulator with saturation and sticky overflow
   always_ff @(posedge clk_i) begin
      if (rst_i || arm_clr) begin
         cnt_q     <= '0;
         ovf_int_q <= 1'b0;
      end else if (tick) begin
         cnt_q <= cnt_inc;
         if (cnt_sat) ovf_int_q <= 1'b1;
      end
   end

   // Result capture and registered status outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         period_q  <= '0;
         ovf_q     <= 1'b0;
         p_valid_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         if (cap_en) begin
`ifdef PM_AVG4_EN
            period_q <= PW'(cnt_cap >> 2);
`else
            period_q <= cnt_cap;
`endif
            ovf_q <= ovf_cap;
         end
         p_valid_q <= (state_d == S_HOLD);
         busy_q    <= (state_d == S_ARM) || (state_d == S_MEAS);
      end
   end

   assign bus.busy    = busy_q;
   assign bus.p_valid = p_valid_q;
   assign bus.period  = period_q;
   assign bus.ovf     = ovf_q;
   assign state_o     = state_q;

endmodule
